// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI loopback block.
package spi_pkg;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned DefDataW    = 12;
  localparam int unsigned DefSclkHalf = 10;
  localparam int unsigned DefDivW     = cnt_w(DefSclkHalf);
  localparam int unsigned DefBitW     = cnt_w(DefDataW);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSend
  } master_state_e;

endpackage

// File: rtl/spi_if.sv
// Bundle of the spi_top host-side signals plus an observation copy of sclk.
interface spi_if #(
  parameter int unsigned DATA_W = 12
) (
  input logic clk
);
  logic              rst;
  logic              newd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              sclk;
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: free-running sclk divider, frame FSM driving cs/mosi.
// Bit order follows SPI_MSB_FIRST_EN (MSB first when defined, LSB first otherwise).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned SCLK_HALF = DefSclkHalf
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic              cs,
  output logic              mosi,
  output logic              sclk_rise,
  output logic              sclk_fall
);

  localparam int unsigned     DivW    = cnt_w(SCLK_HALF);
  localparam int unsigned     BitW    = cnt_w(DATA_W);
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_HALF - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  logic [DivW-1:0]   div_q;
  logic              sclk_q;
  logic              sclk;
  logic              tick;
  master_state_e     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] data_shift;
  logic              next_bit;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;

  // Edge strobes fire in the cycle whose clock edge toggles sclk.
  assign sclk      = sclk_q;
  assign tick      = (div_q == DivLast);
  assign sclk_rise = tick & ~sclk;
  assign sclk_fall = tick & sclk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

`ifdef SPI_MSB_FIRST_EN
  assign next_bit   = data_q[DATA_W-1];
  assign data_shift = {data_q[DATA_W-2:0], 1'b0};
`else
  assign next_bit   = data_q[0];
  assign data_shift = {1'b0, data_q[DATA_W-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      StIdle: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        bit_d  = '0;
        if (newd) begin
          data_d  = din;
          state_d = StWait;
        end
      end
      StWait: begin
        if (sclk_fall) begin
          cs_d    = 1'b0;
          mosi_d  = next_bit;
          data_d  = data_shift;
          bit_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (sclk_fall) begin
          // Last bit has been sampled by the slave; close the frame.
          if (bit_q == BitLast) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = StIdle;
          end else begin
            mosi_d = next_bit;
            data_d = data_shift;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  assign cs   = cs_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: samples mosi on sclk rise strobes while cs is low.
// Bit order follows SPI_MSB_FIRST_EN to match the master.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  localparam int unsigned     BitW    = cnt_w(DATA_W);
  localparam logic [BitW-1:0] BitFull = BitW'(DATA_W);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [BitW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

`ifdef SPI_MSB_FIRST_EN
  assign shift_in = {shift_q[DATA_W-2:0], mosi};
`else
  assign shift_in = {mosi, shift_q[DATA_W-1:1]};
`endif

  // The word is published at the falling edge that closes the last bit slot.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    if (cs) begin
      cnt_d = '0;
    end else if (sclk_rise && (cnt_q != BitFull)) begin
      shift_d = shift_in;
      cnt_d   = cnt_q + 1'b1;
    end else if (sclk_fall && (cnt_q == BitFull)) begin
      dout_d = shift_q;
      done_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;

endmodule

// File: rtl/spi_top.sv
// SPI loopback: master m1 serialises din, slave s1 rebuilds it on dout.
// Optional SPI_MSB_FIRST_EN switches both sides to MSB-first transfer.
module spi_top
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned SCLK_HALF = DefSclkHalf
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  logic cs;
  logic mosi;
  logic sclk_rise;
  logic sclk_fall;

  spi_master #(
    .DATA_W   (DATA_W),
    .SCLK_HALF(SCLK_HALF)
  ) m1 (
    .clk      (clk),
    .rst      (rst),
    .newd     (newd),
    .din      (din),
    .cs       (cs),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  spi_slave #(
    .DATA_W(DATA_W)
  ) s1 (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .dout     (dout),
    .done     (done)
  );

endmodule

// File: tb/tb_spi_top.sv
// Scoreboard bench for spi_top: expected words queued at newd, popped on done.
module tb_spi_top;
  localparam int unsigned DW   = 12;
  localparam int unsigned HALF = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  spi_if #(.DATA_W(DW)) bus (.clk(clk));

  spi_top #(
    .DATA_W   (DW),
    .SCLK_HALF(HALF)
  ) dut (
    .clk (clk),
    .rst (bus.rst),
    .newd(bus.newd),
    .din (bus.din),
    .dout(bus.dout),
    .done(bus.done)
  );

  assign bus.sclk = dut.m1.sclk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int done_cnt = 0;
  int slot_n   = 0;
  int base;
  int t1, t2;
  bit reached;
  logic prev_sclk = 1'b0;
  logic [DW-1:0] slot_vec;
  logic [DW-1:0] exp_w;
  logic [DW-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot_order(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
`ifdef SPI_MSB_FIRST_EN
    for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
`endif
    return r;
  endfunction

  // Monitor: scoreboard pop on done, record mosi at each slave sampling slot.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rst === 1'b1) begin
        if (bus.done === 1'b1) begin
          done_cnt++;
          check_eq("done_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            check_eq("dout", 32'(bus.dout), 32'(exp_w));
          end
        end
        if (!prev_sclk && bus.sclk && !dut.m1.cs) begin
          if (slot_n < DW) slot_vec[slot_n] = dut.m1.mosi;
          slot_n++;
        end
      end
      prev_sclk = bus.sclk;
    end
  end

  // Called at a negedge; newd is high across exactly one rising edge.
  task automatic send(input logic [DW-1:0] w, input bit expect_rx);
    bus.din  = w;
    bus.newd = 1'b1;
    if (expect_rx) begin
      sb.push_back(w);
      slot_n = 0;
    end
    @(negedge clk);
    bus.newd = 1'b0;
    if (expect_rx) t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input logic [DW-1:0] w);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t_acc;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency_240_260"}, 32'(lat >= 240 && lat <= 260), 32'd1);
    check_eq({tag, "_cs_idle"}, 32'(dut.m1.cs), 32'd1);
    check_eq({tag, "_slots"}, 32'(slot_n), 32'(DW));
    check_eq({tag, "_mosi_order"}, 32'(slot_vec), 32'(slot_order(w)));
    @(negedge clk);
    check_eq({tag, "_done_one_clk"}, 32'(bus.done), 32'd0);
  endtask

  task automatic next_sclk_rise(output int t);
    logic p;
    t = -1;
    p = bus.sclk;
    for (int n = 0; n < 100 && t < 0; n++) begin
      @(negedge clk);
      if (!p && bus.sclk) t = cyc;
      p = bus.sclk;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rst  = 1'b0;
    bus.newd = 1'b0;
    bus.din  = '0;
    repeat (5) @(negedge clk);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_cs", 32'(dut.m1.cs), 32'd1);
    check_eq("rst_mosi", 32'(dut.m1.mosi), 32'd0);
    check_eq("rst_sclk", 32'(bus.sclk), 32'd0);
    bus.rst = 1'b1;

    next_sclk_rise(t1);
    next_sclk_rise(t2);
    check_eq("sclk_period", 32'(t2 - t1), 32'd20);
    check_eq("idle_cs", 32'(dut.m1.cs), 32'd1);

    base = done_cnt;
    send(12'hABC, 1'b1);
    wait_done("abc", 12'hABC);
    repeat (300) @(negedge clk);
    check_eq("abc_single_done", 32'(done_cnt - base), 32'd1);

    send(12'h001, 1'b1);
    wait_done("one", 12'h001);

    // Second request during the frame must be ignored, din change included.
    base = done_cnt;
    send(12'h5A5, 1'b1);
    repeat (100) @(negedge clk);
    send(12'hFFF, 1'b0);
    wait_done("inflight", 12'h5A5);
    repeat (300) @(negedge clk);
    check_eq("inflight_single_done", 32'(done_cnt - base), 32'd1);

    base = done_cnt;
    send(12'h000, 1'b1);
    wait_done("b2b_a", 12'h000);
    send(12'hFFF, 1'b1);
    wait_done("b2b_b", 12'hFFF);
    check_eq("b2b_done_count", 32'(done_cnt - base), 32'd2);

    send(12'h3C3, 1'b0);
    slot_n  = 0;
    reached = 1'b0;
    for (int n = 0; n < 300 && !reached; n++) begin
      @(negedge clk);
      if (slot_n >= 6) reached = 1'b1;
    end
    check_eq("abort_reached_bit6", 32'(reached), 32'd1);
    bus.rst = 1'b0;
    @(negedge clk);
    check_eq("abort_cs", 32'(dut.m1.cs), 32'd1);
    check_eq("abort_dout", 32'(bus.dout), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_sclk", 32'(bus.sclk), 32'd0);
    bus.rst = 1'b1;
    base = done_cnt;
    repeat (300) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - base), 32'd0);
    check_eq("abort_dout_held", 32'(bus.dout), 32'd0);
    send(12'h123, 1'b1);
    wait_done("after_abort", 12'h123);

    repeat (50) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
